// File: rtl/nibble_adder_pkg.sv
// Shared constants and helpers for the nibble-serial add/subtract engine.
// Holds nibble width, FSM state encodings and the nibble-count helper.
package nibble_adder_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int nib_count(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle between the controller and the serial adder.
// master = controller side, slave = engine side.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             of;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, of
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, of
  );
endinterface

// File: rtl/adder_4b.sv
// Combinational 4-bit ripple adder stage.
// Exposes the carry into bit 3 so callers can derive signed overflow.
module adder_4b (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_c3,
  output logic       o_cout
);

  logic [4:0] w_c;

  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < 4; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) |
                  (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_c3   = w_c[3];
  assign o_cout = w_c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial WIDTH-bit add/subtract engine, LSB nibble first.
// Define NIBBLE_SERIAL_ADDER_SAT_EN to saturate sum on signed overflow.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nibble_serial_adder_if.slave   bus
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_of;

  logic [3:0]       w_nsum;
  logic             w_c3;
  logic             w_cout;
  logic             w_last;

  adder_4b u_adder (
    .i_a    (r_a[NIB_W*r_idx +: NIB_W]),
    .i_b    (r_b[NIB_W*r_idx +: NIB_W]),
    .i_cin  (r_carry),
    .o_sum  (w_nsum),
    .o_c3   (w_c3),
    .o_cout (w_cout)
  );

  assign w_last = (r_idx == IDX_W'(NIB - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_of    <= 1'b0;
    end else begin
      unique case (1'b1)
        (r_state == ST_IDLE): begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= ST_RUN;
          end
        end
        (r_state == ST_RUN): begin
          r_sum[NIB_W*r_idx +: NIB_W] <= w_nsum;
          r_carry <= w_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_cout  <= w_cout;
            r_of    <= w_c3 ^ w_cout;
            r_state <= ST_DONE;
`ifdef NIBBLE_SERIAL_ADDER_SAT_EN
            // true sign of an overflowed result follows A's sign
            if (w_c3 ^ w_cout)
              r_sum <= r_a[WIDTH-1] ?
                {1'b1, {(WIDTH-1){1'b0}}} :
                {1'b0, {(WIDTH-1){1'b1}}};
`endif
          end
        end
        (r_state == ST_DONE): begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (r_state != ST_IDLE);
  assign bus.done = (r_state == ST_DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.of   = r_of;

endmodule
